// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data-memory arbiter and the data memory.
// Arbiter takes the slave view; requesters and memory together take the master view.
interface dmem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0, req1;
    logic             we0, we1;
    logic [WIDTH-1:0] addr0, addr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic             gnt0, gnt1;
    logic             done0, done1;
    logic             rvalid0, rvalid1;
    logic             err0, err1;
    logic [WIDTH-1:0] rdata;
    logic             memRead, memWrite;
    logic [WIDTH-1:0] memAddress, memWriteData;
    logic [WIDTH-1:0] memReadData;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memReadData,
        output gnt0, gnt1, done0, done1, rvalid0, rvalid1, err0, err1, rdata,
               memRead, memWrite, memAddress, memWriteData
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memReadData,
        input  gnt0, gnt1, done0, done1, rvalid0, rvalid1, err0, err1, rdata,
               memRead, memWrite, memAddress, memWriteData
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-port data memory.
//   state | meaning
//   IDLE  | waiting for a request; winner picked and strobe launched on the grant edge
//   ISSUE | memory strobe high for this cycle, memory acts on the falling edge
//   RESP  | done/rvalid/err pulse for the winner, read data captured
module dmem_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             win_q, win_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             grant;
    logic             in_range_d, in_range_q;

    logic             gnt0_q, gnt1_q, done0_q, done1_q;
    logic             rvalid0_q, rvalid1_q, err0_q, err1_q;
    logic             mem_rd_q, mem_wr_q;
    logic [WIDTH-1:0] rdata_q, mem_addr_q, mem_wdata_q;

    logic             gnt0_d, gnt1_d, done0_d, done1_d;
    logic             rvalid0_d, rvalid1_d, err0_d, err1_d;
    logic             mem_rd_d, mem_wr_d;
    logic [WIDTH-1:0] rdata_d, mem_addr_d, mem_wdata_d;

    assign in_range_d = (addr_d < WIDTH'(DEPTH));
    assign in_range_q = (addr_q < WIDTH'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            win_q       <= win_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // rr_q = 1 means port 1 wins a tie; it only moves when someone is granted
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant   = 1'b1;
                    win_d   = bus.req1 && (!bus.req0 || rr_q);
                    rr_d    = ~win_d;
                    we_d    = win_d ? bus.we1    : bus.we0;
                    addr_d  = win_d ? bus.addr1  : bus.addr0;
                    wdata_d = win_d ? bus.wdata1 : bus.wdata0;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (grant) begin
            gnt0_d      = ~win_d;
            gnt1_d      = win_d;
            mem_addr_d  = addr_d;
            mem_wdata_d = wdata_d;
            mem_rd_d    = in_range_d && !we_d;
            mem_wr_d    = in_range_d && we_d;
        end
        // leaving ISSUE: memReadData was produced on the falling edge of that cycle
        if (state_q == ISSUE) begin
            done0_d = ~win_q;
            done1_d = win_q;
            err0_d  = ~win_q && !in_range_q;
            err1_d  = win_q && !in_range_q;
            if (!we_q) begin
                rvalid0_d = ~win_q;
                rvalid1_d = win_q;
                rdata_d   = in_range_q ? bus.memReadData : '0;
            end
        end
    end

    assign bus.gnt0         = gnt0_q;
    assign bus.gnt1         = gnt1_q;
    assign bus.done0        = done0_q;
    assign bus.done1        = done1_q;
    assign bus.rvalid0      = rvalid0_q;
    assign bus.rvalid1      = rvalid1_q;
    assign bus.err0         = err0_q;
    assign bus.err1         = err1_q;
    assign bus.rdata        = rdata_q;
    assign bus.memRead      = mem_rd_q;
    assign bus.memWrite     = mem_wr_q;
    assign bus.memAddress   = mem_addr_q;
    assign bus.memWriteData = mem_wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_dmem_arbiter;
    localparam int WIDTH = 32;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   checking = 1'b0;

    dmem_arbiter_if #(.WIDTH(WIDTH)) bus ();
    dmem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    // data memory: acts on the falling edge while a strobe is high
    always @(negedge clk) begin
        if (bus.memWrite && bus.memAddress < DEPTH) mem[bus.memAddress[8:0]] <= bus.memWriteData;
        if (bus.memRead && bus.memAddress < DEPTH) bus.memReadData <= mem[bus.memAddress[8:0]];
    end

    // ---------------- transaction-level reference model ----------------
    logic [1:0]  e_gnt, e_done, e_rv, e_err;
    logic        e_rd, e_wr, e_issue;
    logic [31:0] e_rdata, e_addr, e_wdata;
    int          cyc, g_cyc, w, favour;
    bit          busy, t_we;
    logic [31:0] t_addr, t_wdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 0; favour = 0; cyc = 0; g_cyc = 0; w = 0;
            e_gnt = 0; e_done = 0; e_rv = 0; e_err = 0;
            e_rd = 0; e_wr = 0; e_issue = 0; e_rdata = 0; e_addr = 0; e_wdata = 0;
        end else begin
            cyc++;
            e_gnt = 0; e_done = 0; e_rv = 0; e_err = 0; e_rd = 0; e_wr = 0; e_issue = 0;
            if (busy && cyc == g_cyc + 1) begin
                e_done[w] = 1'b1;
                if (t_addr >= DEPTH) e_err[w] = 1'b1;
                if (!t_we) begin
                    e_rv[w] = 1'b1;
                    e_rdata = (t_addr < DEPTH) ? ref_mem[t_addr[8:0]] : 32'h0;
                end
            end else if ((!busy || cyc >= g_cyc + 3) && (bus.req0 || bus.req1)) begin
                w       = (bus.req0 && bus.req1) ? favour : (bus.req1 ? 1 : 0);
                favour  = 1 - w;
                busy    = 1;
                g_cyc   = cyc;
                t_we    = (w == 1) ? bus.we1 : bus.we0;
                t_addr  = (w == 1) ? bus.addr1 : bus.addr0;
                t_wdata = (w == 1) ? bus.wdata1 : bus.wdata0;
                e_gnt[w] = 1'b1;
                e_issue = 1'b1;
                e_addr  = t_addr;
                e_wdata = t_wdata;
                if (t_addr < DEPTH) begin
                    if (t_we) begin
                        e_wr = 1'b1;
                        ref_mem[t_addr[8:0]] = t_wdata;
                    end else begin
                        e_rd = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [9:0] act_vec();
        return {bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.rvalid1, bus.rvalid0,
                bus.err1, bus.err0, bus.memRead, bus.memWrite};
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            tests++;
            if (act_vec() !== {e_gnt, e_done, e_rv, e_err, e_rd, e_wr}) begin
                fails++;
                $display("FAIL strobes t=%0t got %b expected %b (gnt1 gnt0 done1 done0 rv1 rv0 err1 err0 rd wr)",
                         $time, act_vec(), {e_gnt, e_done, e_rv, e_err, e_rd, e_wr});
            end
            tests++;
            if (bus.rdata !== e_rdata) begin
                fails++;
                $display("FAIL rdata t=%0t got 0x%08h expected 0x%08h", $time, bus.rdata, e_rdata);
            end
            if (e_issue) begin
                tests++;
                if (bus.memAddress !== e_addr || bus.memWriteData !== e_wdata) begin
                    fails++;
                    $display("FAIL mem_bus t=%0t got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                             $time, bus.memAddress, bus.memWriteData, e_addr, e_wdata);
                end
            end
            tests++;
            if ((bus.memRead && bus.memWrite) || (bus.gnt0 && bus.gnt1) || (bus.done0 && bus.done1)) begin
                fails++;
                $display("FAIL exclusivity t=%0t got rd/wr=%b%b gnt=%b%b done=%b%b expected at most one of each",
                         $time, bus.memRead, bus.memWrite, bus.gnt0, bus.gnt1, bus.done0, bus.done1);
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    task automatic drive(input int p, input bit r, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = wr; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = wr; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic access(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output int lat_g, output int lat_d, output bit rv, output bit er,
                          output logic [31:0] rd, output bit saw_rd, output bit saw_wr, output bit rd_at_done);
        lat_g = -1; lat_d = -1; rv = 0; er = 0; rd = 0; saw_rd = 0; saw_wr = 0; rd_at_done = 0;
        drive(p, 1'b1, wr, a, d);
        for (int c = 1; c <= 10 && lat_d < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (((p == 0) ? bus.gnt0 : bus.gnt1) && lat_g < 0) begin
                lat_g = c; saw_rd = bus.memRead; saw_wr = bus.memWrite;
                drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if ((p == 0) ? bus.done0 : bus.done1) begin
                lat_d = c;
                rv = (p == 0) ? bus.rvalid0 : bus.rvalid1;
                er = (p == 0) ? bus.err0 : bus.err1;
                rd = bus.rdata;
                rd_at_done = bus.memRead;
            end
        end
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int          lg, ld;
    bit          rv, er, srd, swr, rdd;
    logic [31:0] rd;
    int          gq_cyc[$];
    int          gq_port[$];
    int          dones;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[3] = 32'h0000_0001;
        mem[20] = 32'h0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        checking = 1'b1;
        #1;
        check("reset_strobes", {22'h0, act_vec()}, 32'h0);
        check("reset_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // single read
        access(0, 0, 32'd3, 32'h0, lg, ld, rv, er, rd, srd, swr, rdd);
        check("rd_gnt_lat", lg, 1);
        check("rd_done_lat", ld, 2);
        check("rd_strobe", {30'h0, srd, swr}, 32'h2);
        check("rd_strobe_dropped", {31'h0, rdd}, 32'h0);
        check("rd_flags", {30'h0, rv, er}, 32'h2);
        check("rd_data", rd, 32'h0000_0001);
        idle(2);

        // write then read back on port 1
        access(1, 1, 32'd20, 32'hDEAD_BEEF, lg, ld, rv, er, rd, srd, swr, rdd);
        check("wr_lat", {lg[15:0], ld[15:0]}, {16'd1, 16'd2});
        check("wr_strobe", {30'h0, srd, swr}, 32'h1);
        check("wr_flags", {30'h0, rv, er}, 32'h0);
        idle(2);
        access(1, 0, 32'd20, 32'h0, lg, ld, rv, er, rd, srd, swr, rdd);
        check("wrrd_flags", {30'h0, rv, er}, 32'h2);
        check("wrrd_data", rd, 32'hDEAD_BEEF);
        idle(2);

        // reset in the middle of ISSUE aborts the access
        drive(0, 1, 0, 32'd5, 32'h0);
        @(posedge clk);
        #2;
        check("pre_reset_gnt_rd", {30'h0, bus.gnt0, bus.memRead}, 32'h3);
        rst_n = 1'b0;
        #1;
        check("midreset_strobes", {22'h0, act_vec()}, 32'h0);
        check("midreset_rdata", bus.rdata, 32'h0);
        check("midreset_addr", bus.memAddress, 32'h0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.done0 || bus.done1 || bus.rvalid0) dones++;
        end
        check("post_reset_no_done", dones, 0);
        idle(1);

        // out of range
        access(0, 1, 32'd512, 32'h1234_5678, lg, ld, rv, er, rd, srd, swr, rdd);
        check("oor_wr_lat", {lg[15:0], ld[15:0]}, {16'd1, 16'd2});
        check("oor_wr_strobe", {30'h0, srd, swr}, 32'h0);
        check("oor_wr_flags", {30'h0, rv, er}, 32'h1);
        idle(2);
        access(0, 0, 32'd600, 32'h0, lg, ld, rv, er, rd, srd, swr, rdd);
        check("oor_rd_strobe", {30'h0, srd, swr}, 32'h0);
        check("oor_rd_flags", {30'h0, rv, er}, 32'h3);
        check("oor_rd_data", rd, 32'h0);
        idle(2);

        // contention from reset
        do_reset();
        drive(0, 1, 0, 32'd7, 32'h0);
        drive(1, 1, 0, 32'd9, 32'h0);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.gnt0) begin gq_cyc.push_back(c); gq_port.push_back(0); end
            if (bus.gnt1) begin gq_cyc.push_back(c); gq_port.push_back(1); end
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("cont_grants", gq_cyc.size(), 4);
        for (int i = 0; i < 4 && i < gq_cyc.size(); i++) begin
            check("cont_cycle", gq_cyc[i], 1 + 3 * i);
            check("cont_port", gq_port[i], i % 2);
        end
        idle(3);

        // lone requester on port 1, then a tie
        gq_cyc.delete();
        drive(1, 1, 0, 32'd3, 32'h0);
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.gnt1) begin
                gq_cyc.push_back(c);
                drive(1, 1, 0, 32'(c + 10), 32'h0);
            end
        end
        check("lone_grants", gq_cyc.size(), 3);
        for (int i = 0; i < 3 && i < gq_cyc.size(); i++) check("lone_cycle", gq_cyc[i], 1 + 3 * i);
        drive(0, 1, 0, 32'd4, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("tie_after_lone", {30'h0, bus.gnt1, bus.gnt0}, 32'h1);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        idle(4);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                bit r, g;
                int sel;
                logic [31:0] a;
                r = (p == 0) ? bus.req0 : bus.req1;
                g = (p == 0) ? bus.gnt0 : bus.gnt1;
                if (!r || g) begin
                    if ($urandom_range(0, 1) == 1) begin
                        sel = $urandom_range(0, 9);
                        a = (sel == 0) ? 32'($urandom_range(512, 700)) :
                            (sel == 1) ? 32'($urandom) : 32'($urandom_range(0, 31));
                        drive(p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
                    end else begin
                        drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
                    end
                end
            end
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port, word-addressed data memory.
- Arbitrates between the core load/store port (port 0) and the program/debug loader (port 1).
- Serialises accepted requests into single-cycle memRead/memWrite strobes that the memory samples on the falling edge.
- Captures read data and returns it to the winning requester, together with a completion pulse.

Parameters:
- Width, 32, data and address bus width.
- Depth, 512, number of memory words; addresses >= Depth are out of range.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0, req1  input  1  request from port 0 / port 1; held until the matching gnt is seen.
- we0, we1  input  1  1 = write, 0 = read; stable while req is high.
- addr0, addr1  input  Width  word address; stable while req is high.
- wdata0, wdata1  input  Width  write data; stable while req is high.
- gnt0, gnt1  output  1  one-cycle pulse: request accepted.
- done0, done1  output  1  one-cycle pulse: access complete (read or write).
- rvalid0, rvalid1  output  1  one-cycle pulse with done on reads only.
- err0, err1  output  1  one-cycle pulse with done when the address is out of range.
- rdata  output  Width  read data, valid while any rvalid is high.
- memRead, memWrite  output  1  strobes to the data memory; never both high.
- memAddress, memWriteData  output  Width  to the data memory.
- memReadData  input  Width  from the data memory.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rr_ptr=0 (port 0 favoured).
  - All outputs 0: gnt, done, rvalid, err, rdata, memRead, memWrite, memAddress, memWriteData.
  - A reset during ISSUE or RESP aborts the access: no done, no rvalid; the memory strobe drops immediately.
- FSM IDLE -> ISSUE -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Only one req: that port wins.
  - Both req: if rr_ptr=0, port 0 wins, else port 1.
  - On the posedge that picks a winner: latch we/addr/wdata, pulse gnt of the winner, set rr_ptr to the other port, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - In range: memAddress/memWriteData = latched values; memRead=!we or memWrite=we for this cycle only. The memory acts at the falling edge inside this cycle.
  - Out of range (addr >= Depth): no strobe; memAddress still driven.
  - Always go to RESP.
- RESP (exactly 1 cycle):
  - Strobes are 0.
  - On entry: done pulse for the winner.
  - In-range read: rdata <= memReadData, rvalid pulse.
  - Out of range: err pulse; for a read, rdata=0 and rvalid still pulses.
  - Then go to IDLE.
- rdata holds its last value until the next read completes.
- Latency:
  - req seen in IDLE -> gnt at the next edge (cycle 1).
  - Strobe in cycle 1; done/rvalid in cycle 2.
  - Earliest re-arbitration is cycle 3. Peak throughput is one access per 3 cycles.
- Requesters may drop req or present a new request on the cycle after gnt. req is ignored outside IDLE.
- Fairness:
  - Under continuous requests from both ports, grants strictly alternate.
  - rr_ptr updates only on a grant. A lone requester does not lose priority it was never granted.
- Invariants:
  - memRead & memWrite is never 1.
  - At most one of gnt0/gnt1, and one of done0/done1, is high in any cycle.
  - Exactly one done per gnt unless reset intervenes.

Test Plan:
- Reset values: assert rst_n=0 mid-cycle while in ISSUE -> all outputs 0 asynchronously, and state is IDLE after release with no done.
- Single read: port 0 reads addr 3 (mem[3]=0x00000001) -> gnt0 at edge 1, memRead=1 in cycle 1 only, done0+rvalid0 with rdata=0x00000001 at edge 2.
- Write then read: port 1 writes 0xDEADBEEF to addr 20, then reads addr 20 -> memWrite one cycle, done1 with rvalid1=0; then rvalid1 with rdata=0xDEADBEEF.
- Contention: both ports hold reads continuously for 12 cycles after reset -> grant order 0,1,0,1, one grant every 3 cycles; memRead and memWrite are never high together.
- Out of range: port 0 writes addr 512 -> gnt0, no memWrite, done0+err0. A read of addr 600 -> rvalid0+err0 with rdata=0.
- Lone requester: port 1 alone issues 3 back-to-back reads -> served every 3 cycles. A later simultaneous request -> port 0 wins (rr_ptr=0 after the last port-1 grant).
